// File: rtl/flash_ctrl.sv
// NOR-style flash array with a single-command controller.
// Program only clears bits, erase walks a sector (or the whole array) to all-ones,
// and wp_n guards sector 0. Array contents are not touched by reset.
module flash_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned SECTOR_W    = 6,
  parameter int unsigned PROG_CYCLES = 4,
  parameter string       INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              wp_n,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH      = 2 ** ADDR_W;
  localparam int unsigned SECT_WORDS = 2 ** SECTOR_W;
  localparam int unsigned CYC_W      = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

  localparam logic [CYC_W-1:0]  CYC_LAST   = CYC_W'(PROG_CYCLES - 1);
  localparam logic [ADDR_W-1:0] SECT1_BASE = ADDR_W'(SECT_WORDS);

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_PROG   = 2'b01;
  localparam logic [1:0] OP_SERASE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_PROG,
    S_ERASE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;   // program address, or erase word counter
  logic [ADDR_W-1:0] last_q,  last_d;   // final word of the current erase
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CYC_W-1:0]  cyc_q,   cyc_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_load;

  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] old_word;
  logic              protect_hit;

  logic [DATA_W-1:0] mem [DEPTH];

  // Power-up array image: blank (all-ones).
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '1;
  end

  assign old_word    = mem[addr_q];
  assign protect_hit = ~wp_n & (cmd_addr[ADDR_W-1:SECTOR_W] == '0);

  assign cmd_ready = (state_q == S_IDLE) & rst_n;
  assign busy      = (state_q == S_PROG) | (state_q == S_ERASE);
  assign done      = done_q;
  assign err       = err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

  // Next-state, datapath updates and array write strobe.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_d     = last_q;
    wdata_d    = wdata_q;
    cyc_d      = cyc_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rd_valid_d = 1'b0;
    rd_load    = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = old_word & wdata_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          cyc_d   = '0;
          case (cmd_op)
            OP_READ: begin
              rd_load    = 1'b1;
              rd_valid_d = 1'b1;
              state_d    = S_READ;
            end
            OP_PROG: begin
              if (protect_hit) begin
                done_d = 1'b1;
                err_d  = 1'b1;
              end else begin
                state_d = S_PROG;
              end
            end
            OP_SERASE: begin
              if (protect_hit) begin
                done_d = 1'b1;
                err_d  = 1'b1;
              end else begin
                addr_d  = {cmd_addr[ADDR_W-1:SECTOR_W], {SECTOR_W{1'b0}}};
                last_d  = {cmd_addr[ADDR_W-1:SECTOR_W], {SECTOR_W{1'b1}}};
                state_d = S_ERASE;
              end
            end
            default: begin
              // Chip erase: a protected boot sector is skipped rather than rejected.
              addr_d  = wp_n ? '0 : SECT1_BASE;
              last_d  = '1;
              state_d = S_ERASE;
            end
          endcase
        end
      end
      S_READ: begin
        state_d = S_IDLE;
      end
      S_PROG: begin
        if (cyc_q == CYC_LAST) begin
          mem_we  = 1'b1;
          done_d  = 1'b1;
          err_d   = |(wdata_q & ~old_word);
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_ERASE: begin
        mem_we    = 1'b1;
        mem_wdata = '1;
        // Stop on the last word instead of incrementing, so DEPTH-1 never wraps to 0.
        if (addr_q == last_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      wdata_q    <= '0;
      cyc_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      wdata_q    <= wdata_d;
      cyc_q      <= cyc_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      if (rd_load) rd_data_q <= mem[cmd_addr];
    end
  end

  // Array write port; no reset so contents persist across rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= mem_wdata;
  end

endmodule
